// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op encoding for the LIFO stack
package stack_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

endpackage

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - stack storage: one synchronous write port, one asynchronous read port, no reset
module stack_ram #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/param_lifo_stack.sv
// rtl/param_lifo_stack.sv - parametrised LIFO with registered top peek, replace-top op and sticky error flags
module param_lifo_stack
  import stack_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 256,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;
  logic             is_empty, is_full;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CNT_W'(DEPTH));

  // Slot indices always fit in AW bits because the guards keep count below
  // DEPTH on push and at least 1 (or 2) where an offset is subtracted.
  assign ram_raddr = count_q[AW-1:0] - AW'(2);

  stack_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(data_in),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  always_comb begin
    count_d     = count_q;
    top_d       = top_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q & ~clr_err;
    underflow_d = underflow_q & ~clr_err;
    ram_we      = 1'b0;
    ram_waddr   = count_q[AW-1:0];
    case ({push, pop})
      OP_PUSH: begin
        if (!is_full) begin
          ram_we  = 1'b1;
          count_d = count_q + CNT_W'(1);
          top_d   = data_in;
        end else begin
          overflow_d = 1'b1;
        end
      end
      OP_POP: begin
        if (!is_empty) begin
          data_out_d  = top_q;
          out_valid_d = 1'b1;
          count_d     = count_q - CNT_W'(1);
          top_d       = (count_q == CNT_W'(1)) ? '0 : ram_rdata;
        end else begin
          underflow_d = 1'b1;
        end
      end
      OP_REPL: begin
        out_valid_d = 1'b1;
        if (!is_empty) begin
          data_out_d = top_q;
          ram_we     = 1'b1;
          ram_waddr  = count_q[AW-1:0] - AW'(1);
          top_d      = data_in;
        end else begin
          data_out_d = data_in;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      top_q       <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      top_q       <= top_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign top       = top_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_param_lifo_stack.sv
// tb/tb_param_lifo_stack.sv - self-checking bench for param_lifo_stack
module tb_param_lifo_stack;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, DEPTH=4 for directed boundary tests
  logic       a_push, a_pop, a_clr;
  logic [7:0] a_din, a_dout, a_top;
  logic       a_valid, a_empty, a_full, a_ovf, a_udf;
  logic [2:0] a_cnt;

  // Instance B: WIDTH=8, DEPTH=13 for reset and random tests
  logic       b_push, b_pop, b_clr;
  logic [7:0] b_din, b_dout, b_top;
  logic       b_valid, b_empty, b_full, b_ovf, b_udf;
  logic [3:0] b_cnt;

  param_lifo_stack #(.WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .push(a_push), .pop(a_pop), .data_in(a_din),
    .clr_err(a_clr), .data_out(a_dout), .out_valid(a_valid), .top(a_top),
    .count(a_cnt), .empty(a_empty), .full(a_full), .overflow(a_ovf),
    .underflow(a_udf)
  );

  param_lifo_stack #(.WIDTH(8), .DEPTH(13)) u_b (
    .clk(clk), .rst(rst), .push(b_push), .pop(b_pop), .data_in(b_din),
    .clr_err(b_clr), .data_out(b_dout), .out_valid(b_valid), .top(b_top),
    .count(b_cnt), .empty(b_empty), .full(b_full), .overflow(b_ovf),
    .underflow(b_udf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic a_cyc(input logic p, input logic q, input logic [7:0] d, input logic c);
    a_push = p; a_pop = q; a_din = d; a_clr = c;
    @(posedge clk); #1;
    a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0;
  endtask

  task automatic b_cyc(input logic p, input logic q, input logic [7:0] d, input logic c);
    b_push = p; b_pop = q; b_din = d; b_clr = c;
    @(posedge clk); #1;
    b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0;
  endtask

  logic [7:0] m[$];
  logic [7:0] exp_q[$];
  logic       m_ovf, m_udf, exp_v, e_ovf, e_udf, p, q, c;
  logic [7:0] d, exp_top;

  initial begin
    rst = 1'b1;
    a_push = 0; a_pop = 0; a_din = 0; a_clr = 0;
    b_push = 0; b_pop = 0; b_din = 0; b_clr = 0;
    @(posedge clk); #1;
    check("rst_cnt", a_cnt, 0);
    check("rst_empty", a_empty, 1);
    check("rst_top", a_top, 0);
    check("rst_valid", a_valid, 0);
    check("rst_dout", a_dout, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: async reset mid-cycle with count=5 and a flag set
    b_cyc(0, 1, 8'h00, 0);
    check("t1_udf_set", b_udf, 1);
    for (int i = 0; i < 5; i++) b_cyc(1, 0, 8'(i + 10), 0);
    check("t1_cnt5", b_cnt, 5);
    check("t1_top5", b_top, 8'd14);
    b_push = 1'b1; b_din = 8'h77;
    #2 rst = 1'b1;
    #1;
    check("t1_async_cnt", b_cnt, 0);
    check("t1_async_empty", b_empty, 1);
    check("t1_async_top", b_top, 0);
    check("t1_async_udf", b_udf, 0);
    check("t1_async_ovf", b_ovf, 0);
    b_push = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t1_held_cnt", b_cnt, 0);

    // Test 2: push 1,2,3 then pop x3
    a_cyc(1, 0, 8'd1, 0);
    check("t2_top1", a_top, 1);
    a_cyc(1, 0, 8'd2, 0);
    a_cyc(1, 0, 8'd3, 0);
    check("t2_top3", a_top, 3);
    check("t2_cnt3", a_cnt, 3);
    a_cyc(0, 1, 8'd0, 0);
    check("t2_pop1_dout", a_dout, 3);
    check("t2_pop1_valid", a_valid, 1);
    check("t2_pop1_top", a_top, 2);
    a_cyc(0, 1, 8'd0, 0);
    check("t2_pop2_dout", a_dout, 2);
    check("t2_pop2_top", a_top, 1);
    a_cyc(0, 1, 8'd0, 0);
    check("t2_pop3_dout", a_dout, 1);
    check("t2_pop3_valid", a_valid, 1);
    check("t2_empty", a_empty, 1);
    check("t2_top0", a_top, 0);
    a_cyc(0, 0, 8'd0, 0);
    check("t2_idle_valid", a_valid, 0);
    check("t2_idle_dout", a_dout, 1);

    // Test 3: overflow at DEPTH=4
    for (int i = 0; i < 4; i++) a_cyc(1, 0, 8'(i + 5), 0);
    check("t3_full", a_full, 1);
    check("t3_ovf_before", a_ovf, 0);
    a_cyc(1, 0, 8'd9, 0);
    check("t3_ovf", a_ovf, 1);
    check("t3_cnt", a_cnt, 4);
    check("t3_top", a_top, 8);
    a_cyc(0, 1, 8'd0, 0);
    check("t3_pop_dout", a_dout, 8);
    check("t3_ovf_sticky", a_ovf, 1);
    a_cyc(0, 0, 8'd0, 1);
    check("t3_ovf_clr", a_ovf, 0);
    for (int i = 0; i < 3; i++) a_cyc(0, 1, 8'd0, 0);
    check("t3_drain_dout", a_dout, 5);
    check("t3_drain_empty", a_empty, 1);

    // Test 4: underflow and clear priority
    a_cyc(0, 1, 8'd0, 0);
    check("t4_udf", a_udf, 1);
    check("t4_valid", a_valid, 0);
    check("t4_dout_hold", a_dout, 5);
    a_cyc(0, 0, 8'd0, 1);
    check("t4_udf_clr", a_udf, 0);
    a_cyc(0, 1, 8'd0, 1);
    check("t4_err_wins", a_udf, 1);
    a_cyc(0, 0, 8'd0, 1);

    // Test 5: replace
    a_cyc(1, 0, 8'd1, 0);
    a_cyc(1, 0, 8'd2, 0);
    a_cyc(1, 1, 8'd3, 0);
    check("t5_repl_dout", a_dout, 2);
    check("t5_repl_valid", a_valid, 1);
    check("t5_repl_top", a_top, 3);
    check("t5_repl_cnt", a_cnt, 2);
    a_cyc(0, 1, 8'd0, 0);
    check("t5_pop_new", a_dout, 3);
    check("t5_pop_top", a_top, 1);
    a_cyc(0, 1, 8'd0, 0);
    check("t5_pop_old", a_dout, 1);
    a_cyc(1, 1, 8'd3, 0);
    check("t5_pass_dout", a_dout, 3);
    check("t5_pass_valid", a_valid, 1);
    check("t5_pass_cnt", a_cnt, 0);
    check("t5_pass_udf", a_udf, 0);
    for (int i = 0; i < 4; i++) a_cyc(1, 0, 8'(i + 20), 0);
    a_cyc(1, 1, 8'hAA, 0);
    check("t5_full_repl_dout", a_dout, 23);
    check("t5_full_repl_ovf", a_ovf, 0);
    check("t5_full_repl_top", a_top, 8'hAA);

    // Test 6: random traffic vs queue scoreboard on DEPTH=13
    m_ovf = 0; m_udf = 0;
    for (int i = 0; i < 10000; i++) begin
      int r;
      r = $urandom_range(0, 15);
      if (((i / 300) % 2) == 0) begin
        p = (r < 7) || (r >= 10 && r < 12);
        q = (r >= 7 && r < 12);
      end else begin
        p = (r < 3) || (r >= 10 && r < 12);
        q = (r >= 3 && r < 12);
      end
      d = 8'($urandom);
      c = ($urandom_range(0, 15) == 0);
      exp_v = 0; e_ovf = 0; e_udf = 0;
      case ({p, q})
        2'b10: if (m.size() < 13) m.push_back(d); else e_ovf = 1;
        2'b01: begin
          if (m.size() > 0) begin
            exp_q.push_back(m.pop_back());
            exp_v = 1;
          end else e_udf = 1;
        end
        2'b11: begin
          if (m.size() > 0) begin
            exp_q.push_back(m[m.size()-1]);
            m[m.size()-1] = d;
          end else exp_q.push_back(d);
          exp_v = 1;
        end
        default: ;
      endcase
      m_ovf = (m_ovf & ~c) | e_ovf;
      m_udf = (m_udf & ~c) | e_udf;
      b_cyc(p, q, d, c);
      check("rnd_valid", b_valid, exp_v);
      if (b_valid) begin
        if (exp_q.size() == 0) check("rnd_sb_underrun", 1, 0);
        else check("rnd_dout", b_dout, exp_q.pop_front());
      end
      exp_top = (m.size() > 0) ? m[m.size()-1] : 8'd0;
      check("rnd_cnt", b_cnt, m.size());
      check("rnd_top", b_top, exp_top);
      check("rnd_ovf", b_ovf, m_ovf);
      check("rnd_udf", b_udf, m_udf);
      check("rnd_empty", b_empty, m.size() == 0);
      check("rnd_full", b_full, m.size() == 13);
    end
    check("rnd_sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
